// File: rtl/pwm_pkg.sv
// Shared types, default sizing and helpers for the PWM channel bank.
// PWM_RAMP_EN (optional) enables slew-limited duty updates in pwm_channel.
package pwm_pkg;

    localparam int unsigned DEF_DUTY_W     = 7;
    localparam int unsigned DEF_MAX_DUTY   = 100;
    localparam int unsigned DEF_PERIOD_CYC = 1000;
    localparam int unsigned STEP           = DEF_PERIOD_CYC / DEF_MAX_DUTY;

    typedef logic [DEF_DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RAMP
    } ch_state_t;

    function automatic int unsigned sat_duty(input int unsigned val,
                                             input int unsigned max_duty);
        return (val > max_duty) ? max_duty : val;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty, update FSM and registered output compare.
// With PWM_RAMP_EN defined, active slews toward pending by at most RAMP_STEP per period.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned MAX_DUTY   = DEF_MAX_DUTY,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned RAMP_STEP  = 5,
    parameter int unsigned CNT_W      = $clog2(DEF_PERIOD_CYC + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              boundary,
    input  logic              wr_en,
    input  logic [DUTY_W-1:0] wr_val,
    output logic              pwm_out,
    output logic              upd_pending
);

    localparam int unsigned StepCyc = PERIOD_CYC / MAX_DUTY;

    logic [DUTY_W-1:0] pending_q, pending_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic [DUTY_W-1:0] next_active;
    logic [CNT_W-1:0]  thresh;
    logic              pwm_q;
    ch_state_t         state_q, state_d;

`ifdef PWM_RAMP_EN
    always_comb begin
        if (pending_q > active_q) begin
            next_active = ((pending_q - active_q) > DUTY_W'(RAMP_STEP)) ?
                          active_q + DUTY_W'(RAMP_STEP) : pending_q;
        end else begin
            next_active = ((active_q - pending_q) > DUTY_W'(RAMP_STEP)) ?
                          active_q - DUTY_W'(RAMP_STEP) : pending_q;
        end
    end
`else
    assign next_active = pending_q;
`endif

    always_comb begin
        pending_d = wr_en ? wr_val : pending_q;
        active_d  = active_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                // A boundary-edge write lands in PEND and waits for the next boundary.
                if (pending_d != active_q) state_d = PEND;
            end
            PEND, RAMP: begin
                if (boundary) begin
                    active_d = next_active;
                    if (active_d != pending_q)      state_d = RAMP;
                    else if (pending_d != active_d) state_d = PEND;
                    else                            state_d = IDLE;
                end else if (pending_d == active_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign thresh = CNT_W'(active_q) * CNT_W'(StepCyc);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pending_q <= '0;
            active_q  <= '0;
            state_q   <= IDLE;
            pwm_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            state_q   <= state_d;
            pwm_q     <= (cnt < thresh);
        end
    end

    assign pwm_out     = pwm_q;
    assign upd_pending = (state_q != IDLE);

endmodule

// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM bank: shared period counter, addressed duty command decode, error pulse.
// Define PWM_RAMP_EN to slew-limit duty changes per period in every channel.
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DUTY_W     = DEF_DUTY_W,
    parameter int unsigned MAX_DUTY   = DEF_MAX_DUTY,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned RAMP_STEP  = 5,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              data_ready,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DUTY_W-1:0] control_val,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] upd_pending,
    output logic              cmd_err,
    output logic              period_start
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYC + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic              boundary;
    logic              ch_ok;
    logic              over;
    logic [DUTY_W-1:0] wr_val;
    logic              cmd_err_q;
    logic              period_start_q;

    assign boundary = (cnt_q == CNT_W'(PERIOD_CYC - 1));
    assign ch_ok    = (32'(ch_sel) < NUM_CH);
    assign over     = (32'(control_val) > MAX_DUTY);
    assign wr_val   = DUTY_W'(sat_duty(32'(control_val), MAX_DUTY));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q          <= '0;
            cmd_err_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= boundary ? '0 : cnt_q + CNT_W'(1);
            cmd_err_q      <= data_ready && (!ch_ok || over);
            period_start_q <= boundary;
        end
    end

    assign cmd_err      = cmd_err_q;
    assign period_start = period_start_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = data_ready && ch_ok && (ch_sel == CH_W'(i));

        pwm_channel #(
            .DUTY_W     (DUTY_W),
            .MAX_DUTY   (MAX_DUTY),
            .PERIOD_CYC (PERIOD_CYC),
            .RAMP_STEP  (RAMP_STEP),
            .CNT_W      (CNT_W)
        ) u_channel (
            .clk         (clk),
            .clr         (clr),
            .cnt         (cnt_q),
            .boundary    (boundary),
            .wr_en       (wr_en),
            .wr_val      (wr_val),
            .pwm_out     (pwm_out[i]),
            .upd_pending (upd_pending[i])
        );
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Randomised self-checking bench for pwm_channel_bank against a period-level duty model.
// Builds with or without PWM_RAMP_EN; the model follows the same define.
module tb_pwm_channel_bank;

    // Three channels so a 2-bit select can address an absent channel (3).
    localparam int NCH   = 3;
    localparam int DW    = 7;
    localparam int MAXD  = 100;
    localparam int PER   = 200;
    localparam int RSTEP = 5;
    localparam int STEPC = PER / MAXD;

    logic           clk = 1'b0;
    logic           clr;
    logic           data_ready;
    logic [1:0]     ch_sel;
    logic [DW-1:0]  control_val;
    logic [NCH-1:0] pwm_out;
    logic [NCH-1:0] upd_pending;
    logic           cmd_err;
    logic           period_start;

    always #5 clk = ~clk;

    pwm_channel_bank #(
        .NUM_CH     (NCH),
        .DUTY_W     (DW),
        .MAX_DUTY   (MAXD),
        .PERIOD_CYC (PER),
        .RAMP_STEP  (RSTEP)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .data_ready   (data_ready),
        .ch_sel       (ch_sel),
        .control_val  (control_val),
        .pwm_out      (pwm_out),
        .upd_pending  (upd_pending),
        .cmd_err      (cmd_err),
        .period_start (period_start)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: counter position, per-channel requested and applied duty.
    int m_cnt;
    int m_pend[NCH];
    int m_act[NCH];
    int hi_acc[NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int move_toward(input int a, input int p);
`ifdef PWM_RAMP_EN
        if (p > a) return (p - a > RSTEP) ? a + RSTEP : p;
        else       return (a - p > RSTEP) ? a - RSTEP : p;
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
            hi_acc[i] = 0;
        end
    endtask

    // Advance model and DUT by one clock, then compare all outputs.
    task automatic step();
        bit             bnd;
        bit             e_err;
        logic [NCH-1:0] e_pwm;
        logic [NCH-1:0] e_upd;
        int             old_act[NCH];
        int             sel;
        int             val;
        bnd   = (m_cnt == PER - 1);
        sel   = int'(ch_sel);
        val   = int'(control_val);
        e_err = data_ready && (sel >= NCH || val > MAXD);
        for (int i = 0; i < NCH; i++) begin
            old_act[i] = m_act[i];
            e_pwm[i]   = (m_cnt < m_act[i] * STEPC);
            if (bnd) m_act[i] = move_toward(m_act[i], m_pend[i]);
        end
        if (data_ready && sel < NCH) m_pend[sel] = (val > MAXD) ? MAXD : val;
        m_cnt = bnd ? 0 : m_cnt + 1;
        for (int i = 0; i < NCH; i++) e_upd[i] = (m_pend[i] != m_act[i]);
        @(posedge clk);
        #1;
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("upd_pending", 32'(upd_pending), 32'(e_upd));
        check("cmd_err", 32'(cmd_err), 32'(e_err));
        check("period_start", 32'(period_start), 32'(bnd));
        for (int i = 0; i < NCH; i++) begin
            hi_acc[i] += int'(pwm_out[i]);
            if (bnd) begin
                check($sformatf("hi_cycles[%0d]", i), 32'(hi_acc[i]), 32'(old_act[i] * STEPC));
                hi_acc[i] = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int c);
        for (int k = 0; k < PER && m_cnt != c; k++) step();
    endtask

    task automatic cmd(input int ch, input int val);
        ch_sel      = 2'(ch);
        control_val = DW'(val);
        data_ready  = 1'b1;
        step();
        data_ready  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr         = 1'b1;
        data_ready  = 1'b0;
        ch_sel      = '0;
        control_val = '0;
        model_reset();
        #12;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_upd", 32'(upd_pending), 0);
        check("rst_err", 32'(cmd_err), 0);
        check("rst_ps", 32'(period_start), 0);
        @(negedge clk);
        clr = 1'b0;

        // 50% on ch0, then a full period at the new duty.
        run(3);
        cmd(0, 50);
        run(2 * PER);

        // ch1: 0% (no change) then 100% across the wrap.
        cmd(1, 0);
        run_to(0);
        run(PER);
        cmd(1, 100);
        run(2 * PER + 5);

        // Saturating value and absent channel.
        cmd(0, 120);
        run(3);
        cmd(3, 40);
        run(PER);

        // Last write in a period wins; write on the boundary edge waits a period.
        run_to(10);
        cmd(0, 10);
        run(20);
        cmd(0, 90);
        run_to(PER - 1);
        cmd(2, 30);
        run(2 * PER);

        // Asynchronous reset in the middle of a high pulse.
        run_to(5);
        for (int k = 0; k < 2 * PER && pwm_out[0] !== 1'b1; k++) step();
        check("seek_high", 32'(pwm_out[0]), 1);
        #2;
        clr = 1'b1;
        #1;
        check("async_pwm", 32'(pwm_out), 0);
        check("async_upd", 32'(upd_pending), 0);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        run(PER + 10);

`ifdef PWM_RAMP_EN
        cmd(2, 0);
        for (int k = 0; k < 25 * PER && upd_pending[2] !== 1'b0; k++) step();
        run_to(50);
        cmd(2, 23);
        run(6 * PER);
`endif

        // Random command traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) cmd($urandom_range(0, 3), $urandom_range(0, 127));
            else step();
        end
        run(2 * PER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
